cordic_seq_ctrl: RTL and testbench

//  Sequencer for the shared iterative CORDIC stage.
//  - Accepts one IEEE-754 single-precision angle per transaction over a valid/ready handshake.
//  - Converts the angle to signed fixed point (INTS.FRACS) and loads it into the datapath.
//  - Steps the datapath through ITER micro-rotations, captures the result and presents it
//    on a held valid/ready output.
//  - Sits between the float-facing front end and the single-stage CORDIC rotator.

---
 rtl/cordic_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_seq_ctrl
// Sequencer for the shared single-stage iterative CORDIC rotator.
//
// Takes one IEEE-754 single-precision angle (radians) per transaction. The angle
// is converted to signed fixed point INTS.FRACS and loaded into the datapath.
// The datapath is then stepped through ITER micro-rotations. Its result is
// captured and held on a valid/ready output until the consumer takes it.
//
// Ports
//   clk         in   1        clock, rising edge
//   rst         in   1        synchronous reset, active-high
//   in_valid    in   1        angle request valid
//   in_angle    in   32       IEEE-754 single angle
//   in_ready    out  1        controller can accept an angle (IDLE only)
//   dp_load     out  1        load datapath with dp_z0 and initial x/y
//   dp_z0       out  WIDTH    two's-complement fixed-point angle
//   dp_en       out  1        perform one micro-rotation this cycle
//   dp_iter     out  CW       current micro-rotation index
//   dp_result   in   WIDTH+3  datapath result, valid the cycle after last dp_en
//   out_valid   out  1        result valid
//   out_result  out  WIDTH+3  captured result
//   out_err     out  1        input angle was out of range (saturated)
//   out_ready   in   1        consumer accepts result
//
// States
//   state | meaning
//   IDLE  | waiting for an angle, in_ready high
//   CONV  | present converted angle, pulse dp_load
//   RUN   | ITER cycles of dp_en, dp_iter = count
//   CAPT  | datapath result settles, captured at end of cycle
//   DONE  | out_valid held until out_ready
// -----------------------------------------------------------------------------
module cordic_seq_ctrl #(
  parameter int INTS  = 1,
  parameter int FRACS = 21,
  parameter int ITER  = 16,
  parameter int WIDTH = INTS + FRACS + 1,
  parameter int CW    = $clog2(ITER)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_angle,
  output logic             in_ready,
  output logic             dp_load,
  output logic [WIDTH-1:0] dp_z0,
  output logic             dp_en,
  output logic [CW-1:0]    dp_iter,
  input  logic [WIDTH+2:0] dp_result,
  output logic             out_valid,
  output logic [WIDTH+2:0] out_result,
  output logic             out_err,
  input  logic             out_ready
);

  localparam int MW = INTS + FRACS;
  localparam logic [MW-1:0] MAG_MAX = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    RUN  = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } stateT;

  stateT state;
  stateT stateNext;

  logic [31:0]      angleReg;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] z0Reg;
  logic             errPend;
  logic [WIDTH+2:0] resultReg;
  logic             errReg;
  logic             inReadyReg;

  logic             accept;
  logic             lastIter;

  // float -> fixed conversion
  logic [7:0]       rawExp;
  logic [23:0]      mant;
  int               expVal;
  int               shiftAmt;
  logic [MW-1:0]    convMag;
  logic [WIDTH-1:0] convZ0;
  logic             convErr;

  assign accept   = (state == IDLE) && in_valid && inReadyReg;
  assign lastIter = (count == CW'(ITER - 1));

  assign rawExp = angleReg[30:23];
  assign mant   = {1'b1, angleReg[22:0]};

  always_comb begin
    convMag  = '0;
    convErr  = 1'b0;
    expVal   = int'(rawExp) - 127;
    // bit position of the mantissa LSB relative to the fixed-point LSB
    shiftAmt = expVal + FRACS - 23;
    if (rawExp == 8'd0) begin
      convMag = '0;
    end else if ((rawExp == 8'hFF) || (expVal >= INTS)) begin
      convMag = MAG_MAX;
      convErr = 1'b1;
    end else if (expVal < -FRACS) begin
      convMag = '0;
    end else if (shiftAmt >= 0) begin
      convMag = MW'(mant) << shiftAmt;
    end else begin
      // right shift truncates toward zero on the magnitude
      convMag = MW'(mant >> (-shiftAmt));
    end
    convZ0 = angleReg[31] ? -WIDTH'({1'b0, convMag}) : WIDTH'({1'b0, convMag});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    dp_load   = 1'b0;
    dp_en     = 1'b0;
    dp_iter   = '0;
    out_valid = 1'b0;
    dp_z0     = z0Reg;
    case (state)
      IDLE: begin
        if (accept) stateNext = CONV;
      end
      CONV: begin
        dp_load   = 1'b1;
        dp_z0     = convZ0;
        stateNext = RUN;
      end
      RUN: begin
        dp_en   = 1'b1;
        dp_iter = count;
        if (lastIter) stateNext = CAPT;
      end
      CAPT: begin
        stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // in_ready is registered so it reads 0 in the cycle right after reset,
  // then follows "next state is IDLE".
  always_ff @(posedge clk) begin
    if (rst) begin
      angleReg   <= '0;
      count      <= '0;
      z0Reg      <= '0;
      errPend    <= 1'b0;
      resultReg  <= '0;
      errReg     <= 1'b0;
      inReadyReg <= 1'b0;
    end else begin
      inReadyReg <= (stateNext == IDLE);
      if (accept) angleReg <= in_angle;
      if (state == CONV) begin
        z0Reg   <= convZ0;
        errPend <= convErr;
      end
      if (state == RUN) begin
        count <= lastIter ? '0 : count + CW'(1);
      end else begin
        count <= '0;
      end
      if (state == CAPT) begin
        resultReg <= dp_result;
        errReg    <= errPend;
      end
    end
  end

  assign in_ready   = inReadyReg;
  assign out_result = resultReg;
  assign out_err    = errReg;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
module tb_cordic_seq_ctrl;

  localparam logic [25:0] K = 26'h2A5A5A5;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_angle;
  logic        in_ready;
  logic        dp_load;
  logic [22:0] dp_z0;
  logic        dp_en;
  logic [3:0]  dp_iter;
  logic [25:0] dp_result;
  logic        out_valid;
  logic [25:0] out_result;
  logic        out_err;
  logic        out_ready;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;

  logic [25:0] acc;

  cordic_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_angle  (in_angle),
    .in_ready  (in_ready),
    .dp_load   (dp_load),
    .dp_z0     (dp_z0),
    .dp_en     (dp_en),
    .dp_iter   (dp_iter),
    .dp_result (dp_result),
    .out_valid (out_valid),
    .out_result(out_result),
    .out_err   (out_err),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Toy datapath: load mixes z0 with K, each step adds iter+1.
  always @(posedge clk) begin
    if (dp_load) acc <= {3'b000, dp_z0} ^ K;
    else if (dp_en) acc <= acc + 26'(dp_iter) + 26'd1;
  end
  assign dp_result = acc;

  // 16 steps add 1+2+...+16 = 136
  function automatic logic [25:0] expRes(input logic [22:0] z0);
    return ({3'b000, z0} ^ K) + 26'd136;
  endfunction

  task automatic send(input logic [31:0] a);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    nTests++;
    if (!ok) begin
      nFail++;
      $display("FAIL send_ready_timeout angle=%h in_ready=%b want 1", a, in_ready);
    end
    in_angle = a;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_angle = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    nTests++;
    if ({in_ready, dp_load, dp_en, dp_iter, out_valid, out_err, dp_z0, out_result} !== '0) begin
      nFail++;
      $display("FAIL reset_outputs got rdy=%b ld=%b en=%b it=%h ov=%b err=%b z0=%h res=%h want all 0",
               in_ready, dp_load, dp_en, dp_iter, out_valid, out_err, dp_z0, out_result);
    end
    rst = 1'b0;
    @(negedge clk);
    nTests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nFail++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_one();
    out_ready = 1'b1;
    send(32'h3F800000);
    nTests++;
    if (dp_load !== 1'b1 || dp_en !== 1'b0 || dp_z0 !== 23'h200000) begin
      nFail++;
      $display("FAIL one_conv got load=%b en=%b z0=%h want 1/0/200000", dp_load, dp_en, dp_z0);
    end
    nTests++;
    if (in_ready !== 1'b0) begin
      nFail++;
      $display("FAIL one_busy_ready got %b want 0", in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      nTests++;
      if (dp_en !== 1'b1 || dp_load !== 1'b0 || dp_iter !== 4'(i)) begin
        nFail++;
        $display("FAIL one_run_step[%0d] got en=%b load=%b iter=%0d want 1/0/%0d",
                 i, dp_en, dp_load, dp_iter, i);
      end
    end
    @(negedge clk);
    nTests++;
    if (dp_en !== 1'b0 || out_valid !== 1'b0 || dp_iter !== 4'd0) begin
      nFail++;
      $display("FAIL one_capt got en=%b ov=%b iter=%0d want 0/0/0", dp_en, out_valid, dp_iter);
    end
    @(negedge clk);
    nTests++;
    if (out_valid !== 1'b1) begin
      nFail++;
      $display("FAIL one_latency out_valid=%b at k+19 want 1", out_valid);
    end
    nTests++;
    if (out_result !== expRes(23'h200000) || out_err !== 1'b0) begin
      nFail++;
      $display("FAIL one_result got %h err=%b want %h err=0", out_result, out_err, expRes(23'h200000));
    end
    @(negedge clk);
    nTests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nFail++;
      $display("FAIL one_return_idle got ov=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_conversion();
    logic [31:0] angTab [14];
    logic [22:0] z0Tab  [14];
    logic        errTab [14];
    bit ok;
    angTab = '{32'h00000000, 32'h80000000, 32'hBF000000, 32'h40800000, 32'hC0800000,
               32'h7F800000, 32'h3FC00000, 32'hBFC00000, 32'h34000000, 32'h35000000,
               32'hB5000000, 32'h3FFFFFFF, 32'h40000000, 32'h00000001};
    z0Tab  = '{23'h000000, 23'h000000, 23'h700000, 23'h3FFFFF, 23'h400001,
               23'h3FFFFF, 23'h300000, 23'h500000, 23'h000000, 23'h000001,
               23'h7FFFFF, 23'h3FFFFF, 23'h3FFFFF, 23'h000000};
    errTab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(angTab[i]);
      nTests++;
      if (dp_load !== 1'b1 || dp_z0 !== z0Tab[i]) begin
        nFail++;
        $display("FAIL conv_z0[%0d] angle=%h got load=%b z0=%h want 1/%h",
                 i, angTab[i], dp_load, dp_z0, z0Tab[i]);
      end
      wait_valid(ok);
      nTests++;
      if (!ok || out_result !== expRes(z0Tab[i]) || out_err !== errTab[i]) begin
        nFail++;
        $display("FAIL conv_out[%0d] angle=%h got ov=%b res=%h err=%b want 1/%h/%b",
                 i, angTab[i], out_valid, out_result, out_err, expRes(z0Tab[i]), errTab[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    send(32'h40800000);
    wait_valid(ok);
    nTests++;
    if (!ok) begin
      nFail++;
      $display("FAIL bp_valid_timeout out_valid=%b want 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_angle = 32'h3F800000;
      nTests++;
      if (out_valid !== 1'b1 || out_result !== expRes(23'h3FFFFF) || out_err !== 1'b1 ||
          in_ready !== 1'b0 || dp_load !== 1'b0) begin
        nFail++;
        $display("FAIL bp_hold[%0d] got ov=%b res=%h err=%b rdy=%b ld=%b want 1/%h/1/0/0",
                 i, out_valid, out_result, out_err, in_ready, dp_load, expRes(23'h3FFFFF));
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    nTests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dp_load !== 1'b0 || out_err !== 1'b1) begin
      nFail++;
      $display("FAIL bp_release got ov=%b rdy=%b ld=%b err=%b want 0/1/0/1",
               out_valid, in_ready, dp_load, out_err);
    end
  endtask

  task automatic test_reset_midrun();
    bit found;
    int enCount;
    bit ok;
    out_ready = 1'b1;
    send(32'h3F800000);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (dp_en === 1'b1 && dp_iter === 4'd7) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    nTests++;
    if (!found) begin
      nFail++;
      $display("FAIL midrun_iter7_timeout dp_iter=%0d want 7", dp_iter);
    end
    rst = 1'b1;
    @(negedge clk);
    nTests++;
    if ({in_ready, dp_load, dp_en, dp_iter, out_valid, out_err, dp_z0, out_result} !== '0) begin
      nFail++;
      $display("FAIL midrun_reset got rdy=%b ld=%b en=%b it=%h ov=%b err=%b z0=%h res=%h want all 0",
               in_ready, dp_load, dp_en, dp_iter, out_valid, out_err, dp_z0, out_result);
    end
    rst = 1'b0;
    @(negedge clk);
    nTests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dp_en !== 1'b0) begin
      nFail++;
      $display("FAIL midrun_idle got rdy=%b ov=%b en=%b want 1/0/0", in_ready, out_valid, dp_en);
    end
    send(32'hBF000000);
    nTests++;
    if (dp_load !== 1'b1 || dp_z0 !== 23'h700000) begin
      nFail++;
      $display("FAIL midrun_conv got load=%b z0=%h want 1/700000", dp_load, dp_z0);
    end
    enCount = 0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1;
        break;
      end
      if (dp_en === 1'b1) enCount++;
    end
    nTests++;
    if (!ok || enCount != 16) begin
      nFail++;
      $display("FAIL midrun_steps got valid=%b steps=%0d want 1/16", ok, enCount);
    end
    nTests++;
    if (out_result !== expRes(23'h700000) || out_err !== 1'b0) begin
      nFail++;
      $display("FAIL midrun_result got %h err=%b want %h err=0", out_result, out_err, expRes(23'h700000));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] angs [3];
    logic [22:0] z0s  [3];
    logic        errs [3];
    int accCyc [3];
    int nAcc;
    int nRes;
    angs = '{32'h3F800000, 32'hC0800000, 32'h3E800000};
    z0s  = '{23'h200000, 23'h400001, 23'h080000};
    errs = '{1'b0, 1'b1, 1'b0};
    accCyc = '{0, 0, 0};
    nAcc = 0;
    nRes = 0;
    out_ready = 1'b1;
    in_angle  = angs[0];
    in_valid  = 1'b1;
    for (int c = 0; c < 100 && nRes < 3; c++) begin
      if (out_valid === 1'b1) begin
        nTests++;
        if (out_result !== expRes(z0s[nRes]) || out_err !== errs[nRes]) begin
          nFail++;
          $display("FAIL b2b_result[%0d] got %h err=%b want %h err=%b",
                   nRes, out_result, out_err, expRes(z0s[nRes]), errs[nRes]);
        end
        nRes++;
      end
      if (in_ready === 1'b1 && in_valid === 1'b1) begin
        accCyc[nAcc] = cyc;
        nAcc++;
      end else if (in_ready !== 1'b1) begin
        if (nAcc < 3) in_angle = angs[nAcc];
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    nTests++;
    if (nRes != 3 || nAcc != 3) begin
      nFail++;
      $display("FAIL b2b_count got results=%0d accepts=%0d want 3/3", nRes, nAcc);
    end
    nTests++;
    if (accCyc[1] - accCyc[0] != 20) begin
      nFail++;
      $display("FAIL b2b_spacing01 got %0d want 20", accCyc[1] - accCyc[0]);
    end
    nTests++;
    if (accCyc[2] - accCyc[1] != 20) begin
      nFail++;
      $display("FAIL b2b_spacing12 got %0d want 20", accCyc[2] - accCyc[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_one();
    test_conversion();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
